// File: rtl/hdc_feature_assembler.sv
// hdc_feature_assembler
//   Collects one quantized channel feature per beat and assembles them into a
//   full-width frame for hdc_sensor_fusion. The design is double-buffered: an
//   assembly buffer fills while the output register holds the previous frame
//   until the fusion core takes it.
//   Optional macro HDC_FEAT_DROP_CNT_EN adds a saturating 16-bit count of
//   discarded (malformed) frames on output drop_count.

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 2
`endif

module hdc_feature_assembler #(
  parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
  parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH,
  parameter int IDX_WIDTH     = $clog2(NUM_CHANNEL)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNEL_WIDTH-1:0]           ch_data,
  input  logic                               ch_valid,
  input  logic                               ch_last,
  output logic                               ch_ready,
  output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
  output logic                               fout_valid,
  input  logic                               fout_ready,
  output logic                               frame_err
`ifdef HDC_FEAT_DROP_CNT_EN
  ,
  output logic [15:0]                        drop_count
`endif
);

  localparam int FRAME_WIDTH = NUM_CHANNEL * CHANNEL_WIDTH;

  localparam logic ST_FILL     = 1'b0;
  localparam logic ST_COMPLETE = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNEL - 1);

  logic                   state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [FRAME_WIDTH-1:0] asm_q, asm_d;
  logic [FRAME_WIDTH-1:0] out_q, out_d;
  logic                   fout_valid_q, fout_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic                   out_free;
  logic                   accept;
  logic                   at_last_idx;
  logic [FRAME_WIDTH-1:0] merged;

  // Output register can take a new frame when empty or being consumed now.
  assign out_free = !fout_valid_q || fout_ready;
  // FILL always accepts; COMPLETE accepts only in the cycle its frame leaves.
  assign ch_ready = (state_q == ST_FILL) || out_free;
  assign accept   = ch_valid && ch_ready;

  // Next-state logic for the assembly FSM, index, buffers and status flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    out_d        = out_q;
    fout_valid_d = fout_valid_q;
    frame_err_d  = 1'b0;
    at_last_idx  = (idx_q == LAST_IDX);
    merged       = asm_q;
    merged[idx_q*CHANNEL_WIDTH +: CHANNEL_WIDTH] = ch_data;

    // Consumed frame leaves the output register unless replaced below.
    if (fout_valid_q && fout_ready) begin
      fout_valid_d = 1'b0;
    end

    // A completed frame waiting in the assembly buffer moves out first.
    if (state_q == ST_COMPLETE && out_free) begin
      out_d        = asm_q;
      fout_valid_d = 1'b1;
      state_d      = ST_FILL;
    end

    // In COMPLETE, idx_q is 0, so a beat here starts the next frame and
    // can never be a legal last beat (NUM_CHANNEL >= 2).
    if (accept) begin
      if (ch_last != at_last_idx) begin
        // Malformed frame: drop the partial data and restart at channel 0.
        frame_err_d = 1'b1;
        idx_d       = '0;
      end else if (at_last_idx) begin
        idx_d = '0;
        if (out_free) begin
          out_d        = merged;
          fout_valid_d = 1'b1;
        end else begin
          asm_d   = merged;
          state_d = ST_COMPLETE;
        end
      end else begin
        asm_d = merged;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: the assembly buffer is reset too, so a frame interrupted by rst
    // can never leak stale channels into a later frame.
    if (rst) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      asm_q        <= '0;
      out_q        <= '0;
      fout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge value of its neighbours.
      state_q      <= state_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      out_q        <= out_d;
      fout_valid_q <= fout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign features_top = out_q;
  assign fout_valid   = fout_valid_q;
  assign frame_err    = frame_err_q;

`ifdef HDC_FEAT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of discarded frames, updated with the frame_err pulse.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_err_d && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
